dual_grant_scheduler: RTL

- Shares two identical service slots (slot0, slot1) among 12 requesters.
- Each cycle, every free slot is assigned to the highest-priority pending requester. Slots are filled in the same highest/second-highest order a dual priority encoder produces.
- A slot is held until its consumer signals done or a timeout expires.
- Sits between request sources and a two-lane shared resource; all outputs are registered.

---
 rtl/dual_grant_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dual_grant_scheduler.sv
// Two-slot scheduler: each free slot goes to the best pending requester and is held until done or timeout.
// Define DUAL_GRANT_SCHED_RR_EN for rotating priority; otherwise priority is fixed (highest index wins).
module dual_grant_scheduler #(
    parameter int unsigned N_REQ   = 12,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             done0,
    input  logic             done1,
    output logic             gnt0_valid,
    output logic [3:0]       gnt0_idx,
    output logic             gnt1_valid,
    output logic [3:0]       gnt1_idx,
    output logic             timeout0,
    output logic             timeout1
);
    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t           r_state [2];
    logic [3:0]       r_idx   [2];
    logic [7:0]       r_cnt   [2];
    logic [1:0]       r_to;

    state_t           w_state_nxt [2];
    logic [3:0]       w_idx_nxt   [2];
    logic [7:0]       w_cnt_nxt   [2];
    logic [1:0]       w_to_nxt;
    logic [1:0]       w_done;
    logic [N_REQ-1:0] w_cand;
    logic [3:0]       w_start;
    logic [3:0]       w_pos;
    logic             w_first_vld;
    logic [3:0]       w_first_idx;
    logic             w_second_vld;
    logic [3:0]       w_second_idx;
    logic [1:0]       w_grant;
    logic [3:0]       w_grant_idx [2];

    assign w_done = {done1, done0};

`ifdef DUAL_GRANT_SCHED_RR_EN
    logic [3:0] r_ptr;

    // Pointer follows the most recent grant; slot1 wins on a double grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_grant[1]) begin
            r_ptr <= w_grant_idx[1];
        end else if (w_grant[0]) begin
            r_ptr <= w_grant_idx[0];
        end
    end

    assign w_start = r_ptr;
`else
    assign w_start = '0;
`endif

    always_comb begin
        w_cand = req;
        for (int unsigned s = 0; s < 2; s++) begin
            if (r_state[s] == S_BUSY) begin
                w_cand[r_idx[s]] = 1'b0;
            end
        end
    end

    // Walk downward from start-1, wrapping 0 -> N_REQ-1; start 0 gives plain high-index-first.
    always_comb begin
        w_first_vld  = 1'b0;
        w_first_idx  = '0;
        w_second_vld = 1'b0;
        w_second_idx = '0;
        w_pos        = w_start;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_pos = (w_pos == 4'd0) ? 4'(N_REQ - 1) : w_pos - 4'd1;
            if (w_cand[w_pos]) begin
                if (!w_first_vld) begin
                    w_first_vld = 1'b1;
                    w_first_idx = w_pos;
                end else if (!w_second_vld) begin
                    w_second_vld = 1'b1;
                    w_second_idx = w_pos;
                end
            end
        end
    end

    always_comb begin
        w_grant        = '0;
        w_grant_idx[0] = w_first_idx;
        w_grant_idx[1] = w_first_idx;
        w_grant[0]     = (r_state[0] == S_IDLE) && w_first_vld;
        if (r_state[0] == S_IDLE) begin
            w_grant[1]     = (r_state[1] == S_IDLE) && w_second_vld;
            w_grant_idx[1] = w_second_idx;
        end else begin
            w_grant[1]     = (r_state[1] == S_IDLE) && w_first_vld;
        end
    end

    always_comb begin
        w_to_nxt = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            w_state_nxt[s] = r_state[s];
            w_idx_nxt[s]   = r_idx[s];
            w_cnt_nxt[s]   = r_cnt[s];
            if (r_state[s] == S_IDLE) begin
                if (w_grant[s]) begin
                    w_state_nxt[s] = S_BUSY;
                    w_idx_nxt[s]   = w_grant_idx[s];
                    w_cnt_nxt[s]   = '0;
                end
            end else if (w_done[s]) begin
                w_state_nxt[s] = S_IDLE;
            end else if ((TIMEOUT != 0) && (({1'b0, r_cnt[s]} + 9'd1) >= 9'(TIMEOUT))) begin
                w_state_nxt[s] = S_IDLE;
                w_to_nxt[s]    = 1'b1;
            end else if (r_cnt[s] != '1) begin
                w_cnt_nxt[s] = r_cnt[s] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < 2; s++) begin
                r_state[s] <= S_IDLE;
                r_idx[s]   <= '0;
                r_cnt[s]   <= '0;
            end
            r_to <= '0;
        end else begin
            for (int unsigned s = 0; s < 2; s++) begin
                r_state[s] <= w_state_nxt[s];
                r_idx[s]   <= w_idx_nxt[s];
                r_cnt[s]   <= w_cnt_nxt[s];
            end
            r_to <= w_to_nxt;
        end
    end

    assign gnt0_valid = (r_state[0] == S_BUSY);
    assign gnt1_valid = (r_state[1] == S_BUSY);
    assign gnt0_idx   = r_idx[0];
    assign gnt1_idx   = r_idx[1];
    assign timeout0   = r_to[0];
    assign timeout1   = r_to[1];

endmodule
